// File: rtl/segment_dp_if.sv
// Emin engine handshake: segment_dp drives the request side (master), the Emin engine answers (slave).
interface segment_dp_if #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160
);
    logic [$clog2(I)-1:0]        emin_i_out;
    logic                        emin_valid_out;
    logic [$clog2(I)-1:0]        emin_j_in;
    logic signed [BIT_WIDTH-1:0] emin_data_in;
    logic                        emin_valid_in;
    logic                        emin_done_in;

    modport master (
        output emin_i_out, emin_valid_out,
        input  emin_j_in, emin_data_in, emin_valid_in, emin_done_in
    );
    modport slave (
        input  emin_i_out, emin_valid_out,
        output emin_j_in, emin_data_in, emin_valid_in, emin_done_in
    );
endinterface

// File: rtl/segment_dp.sv
// Segmentation DP: D(i) = min_j [D(j-1) + Emin(j,i)], B(i) = argmin j, with saturating signed costs.
// Optional macro SEG_PENALTY_EN adds SEG_PENALTY to every candidate through one extra pipeline stage.
module segment_dp #(
    parameter int BIT_WIDTH   = 32,
    parameter int I           = 160,
    parameter int SEG_PENALTY = 0
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start_in,
    segment_dp_if.master                emin,
    output logic                        busy_out,
    output logic                        done_out,
    output logic                        seq_err_out,
    input  logic [$clog2(I)-1:0]        rd_addr_in,
    output logic signed [BIT_WIDTH-1:0] rd_cost_out,
    output logic [$clog2(I)-1:0]        rd_bp_out
);
    localparam int IW = $clog2(I);
    localparam logic signed [BIT_WIDTH-1:0] MAXV = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [BIT_WIDTH-1:0] MINV = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_ACCUM  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

`ifdef SEG_PENALTY_EN
    localparam logic [1:0] DRAIN_LAST = 2'd2;
    localparam logic signed [BIT_WIDTH-1:0] PEN = BIT_WIDTH'(SEG_PENALTY);
`else
    localparam logic [1:0] DRAIN_LAST = 2'd1;
`endif

    function automatic logic signed [BIT_WIDTH-1:0] sat_add(
        input logic signed [BIT_WIDTH-1:0] a,
        input logic signed [BIT_WIDTH-1:0] b
    );
        logic signed [BIT_WIDTH:0] s;
        s = {a[BIT_WIDTH-1], a} + {b[BIT_WIDTH-1], b};
        if (s[BIT_WIDTH] != s[BIT_WIDTH-1])
            return s[BIT_WIDTH] ? MINV : MAXV;
        return s[BIT_WIDTH-1:0];
    endfunction

    logic [2:0]                  state_q, state_d;
    logic [IW-1:0]               i_q, i_d;
    logic [IW:0]                 expj_q, expj_d;
    logic                        err_q, err_d;
    logic [1:0]                  drain_q, drain_d;
    logic                        wr_en;
    logic                        acc_vld;

    logic signed [BIT_WIDTH-1:0] d_mem [I];
    logic [IW-1:0]               b_mem [I];

    logic [IW-1:0]               jm1;
    logic signed [BIT_WIDTH-1:0] prev_rd;
    logic                        vld_p1_q;
    logic [IW-1:0]               j_p1_q;
    logic signed [BIT_WIDTH-1:0] data_p1_q, prev_p1_q;
    logic                        cmp_vld;
    logic [IW-1:0]               cmp_j;
    logic signed [BIT_WIDTH-1:0] cmp_cand;
    logic signed [BIT_WIDTH-1:0] best_q;
    logic [IW-1:0]               bestj_q;

    assign acc_vld             = (state_q == S_ACCUM) && emin.emin_valid_in;
    assign jm1                 = emin.emin_j_in - IW'(1);
    assign prev_rd             = (emin.emin_j_in == '0) ? '0 : d_mem[jm1];
    assign emin.emin_valid_out = (state_q == S_ISSUE);
    assign emin.emin_i_out     = i_q;
    assign busy_out            = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done_out            = (state_q == S_FINISH);
    assign seq_err_out         = err_q;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        expj_d  = expj_q;
        err_d   = err_q;
        drain_d = drain_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    i_d     = '0;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                expj_d  = '0;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (emin.emin_valid_in) begin
                    if ({1'b0, emin.emin_j_in} != expj_q)
                        err_d = 1'b1;
                    expj_d = expj_q + (IW+1)'(1);
                    if (emin.emin_done_in) begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == DRAIN_LAST)
                    state_d = S_COMMIT;
            end
            S_COMMIT: begin
                wr_en = 1'b1;
                if (expj_q != ({1'b0, i_q} + (IW+1)'(1)))
                    err_d = 1'b1;
                if (i_q == IW'(I-1)) begin
                    state_d = S_FINISH;
                end else begin
                    i_d     = i_q + IW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            expj_q      <= '0;
            err_q       <= 1'b0;
            drain_q     <= '0;
            vld_p1_q    <= 1'b0;
            rd_cost_out <= '0;
            rd_bp_out   <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            expj_q      <= expj_d;
            err_q       <= err_d;
            drain_q     <= drain_d;
            vld_p1_q    <= acc_vld;
            rd_cost_out <= d_mem[rd_addr_in];
            rd_bp_out   <= b_mem[rd_addr_in];
        end
    end

    // Stage 1: capture the Emin value together with its predecessor cost D(j-1).
    always_ff @(posedge clk_in) begin
        if (acc_vld) begin
            j_p1_q    <= emin.emin_j_in;
            data_p1_q <= emin.emin_data_in;
            prev_p1_q <= prev_rd;
        end
    end

`ifdef SEG_PENALTY_EN
    logic                        vld_p2_q;
    logic [IW-1:0]               j_p2_q;
    logic signed [BIT_WIDTH-1:0] cand_p2_q;

    // Stage 2: penalised candidate registered ahead of the compare.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            vld_p2_q <= 1'b0;
        else
            vld_p2_q <= vld_p1_q;
    end

    always_ff @(posedge clk_in) begin
        if (vld_p1_q) begin
            j_p2_q    <= j_p1_q;
            cand_p2_q <= sat_add(sat_add(prev_p1_q, data_p1_q), PEN);
        end
    end

    assign cmp_vld  = vld_p2_q;
    assign cmp_j    = j_p2_q;
    assign cmp_cand = cand_p2_q;
`else
    logic unused_pen;
    assign unused_pen = ^SEG_PENALTY;
    assign cmp_vld    = vld_p1_q;
    assign cmp_j      = j_p1_q;
    assign cmp_cand   = sat_add(prev_p1_q, data_p1_q);
`endif

    // Compare stage: strict less-than so the earliest j wins ties.
    always_ff @(posedge clk_in) begin
        if (state_q == S_ISSUE) begin
            best_q  <= MAXV;
            bestj_q <= '0;
        end else if (cmp_vld && (cmp_cand < best_q)) begin
            best_q  <= cmp_cand;
            bestj_q <= cmp_j;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            d_mem[i_q] <= best_q;
            b_mem[i_q] <= bestj_q;
        end
    end
endmodule
